alu_req_arbiter: RTL

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_core.sv | 48 ++++
 rtl/alu_req_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and latency defaults
// for the two-requester ALU arbiter.
package alu_pkg;

  localparam int W_DEF       = 8;
  localparam int MUL_LAT_DEF = 2;
  localparam int DIV_LAT_DEF = 4;

  localparam logic [3:0] OP_SNE  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_MIN  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_DIV  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SGE  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [7:0] op_lat(
    input logic [3:0] op,
    input int         mul_lat,
    input int         div_lat
  );
    if (op == OP_MUL) return 8'(mul_lat);
    if (op == OP_DIV) return 8'(div_lat);
    return 8'd1;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational result datapath: opcode and operands in,
// result, carry and error out.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [3:0]   opcode,
  input  logic [W-1:0] input1,
  input  logic [W-1:0] input2,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         err
);

  logic [W:0]   sum;
  logic [W-1:0] prod;

  assign sum  = {1'b0, input1} + {1'b0, input2};
  assign prod = input1 * input2;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    err    = 1'b0;
    unique case (opcode)
      OP_SNE:  result = W'(input1 != input2);
      OP_ADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
      end
      OP_SLT:  result = W'($signed(input1) < $signed(input2));
      OP_NOR:  result = ~(input1 | input2);
      OP_MIN:  result = (input1 < input2) ? input1 : input2;
      OP_AND:  result = input1 & input2;
      OP_DIV: begin
        if (input2 == '0) err = 1'b1;
        else result = input1 / input2;
      end
      OP_SLTU: result = W'(input1 < input2);
      OP_SGE:  result = W'($signed(input1) >= $signed(input2));
      OP_XNOR: result = ~(input1 ^ input2);
      OP_MUL:  result = prod;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter feeding one shared multi-cycle ALU;
// one operation in flight, response held until consumed.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_opcode,
  input  logic [W-1:0] req0_input1,
  input  logic [W-1:0] req0_input2,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_opcode,
  input  logic [W-1:0] req1_input1,
  input  logic [W-1:0] req1_input2,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_result,
  output logic         resp_carry,
  output logic         resp_id,
  output logic         resp_err,
  output logic         busy
);

  state_t       state, state_n;
  logic         ptr;
  logic         gnt_any, gnt_id, hs;
  logic [3:0]   sel_op;
  logic [3:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic         id_q;
  logic [7:0]   cnt;
  logic [W-1:0] res_c;
  logic         carry_c, err_c;

  // Pointer only breaks ties; a lone requester always wins.
  assign gnt_any = req0_valid | req1_valid;
  assign gnt_id  = (req0_valid & req1_valid) ? ptr : req1_valid;
  assign sel_op  = gnt_id ? req1_opcode : req0_opcode;

  assign req0_ready = ~rst & (state == S_IDLE) & gnt_any & ~gnt_id;
  assign req1_ready = ~rst & (state == S_IDLE) & gnt_any & gnt_id;
  assign hs         = req0_ready | req1_ready;

  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  alu_core #(.W(W)) u_core (
    .opcode (op_q),
    .input1 (a_q),
    .input2 (b_q),
    .result (res_c),
    .carry  (carry_c),
    .err    (err_c)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (hs) state_n = S_EXEC;
      S_EXEC: if (cnt == 8'd0) state_n = S_RESP;
      S_RESP: if (resp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      cnt         <= '0;
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_id     <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (hs) begin
        op_q <= sel_op;
        a_q  <= gnt_id ? req1_input1 : req0_input1;
        b_q  <= gnt_id ? req1_input2 : req0_input2;
        id_q <= gnt_id;
        ptr  <= ~gnt_id;
        cnt  <= op_lat(sel_op, MUL_LAT, DIV_LAT) - 8'd1;
      end
      if (state == S_EXEC) begin
        if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
        end else begin
          resp_result <= res_c;
          resp_carry  <= carry_c;
          resp_id     <= id_q;
          resp_err    <= err_c;
        end
      end
    end
  end

endmodule
